led_scanner_pwm: RTL

Parametrised LED scanner with a per-channel PWM fade trail. A single lit position moves across `LED_CNT` outputs in bounce, wrap-up, wrap-down or freeze mode. Each newly lit channel is set to full brightness, and every channel then decays toward zero at a programmable rate. It drives the board LED bank directly and replaces the fixed 18-LED bounce design with one that is configurable at build time and at run time.

---
 rtl/led_scanner_pwm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_scanner_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_scanner_pwm
// Purpose  : LED position scanner (bounce/wrap/freeze) with per-channel PWM fade trail
// Revision : 1.0
// ============================================================================
module led_scanner_pwm #(
  parameter int LED_CNT        = 18,
  parameter int PWM_BITS       = 8,
  parameter int MAX_BRIGHTNESS = 200,
  parameter int TICK_DIV       = 50000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [15:0]                step_ticks,
  input  logic [PWM_BITS-1:0]        fade_rate,
  input  logic [LED_CNT-1:0]         mask,
  output logic [LED_CNT-1:0]         led,
  output logic [$clog2(LED_CNT)-1:0] pos,
  output logic                       dir,
  output logic                       step
);

  localparam int c_tw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_pw = $clog2(LED_CNT);
  localparam logic [c_tw-1:0]     c_tick_last = c_tw'(TICK_DIV - 1);
  localparam logic [c_pw-1:0]     c_pos_last  = c_pw'(LED_CNT - 1);
  localparam logic [PWM_BITS-1:0] c_full      = PWM_BITS'(MAX_BRIGHTNESS);
  localparam logic [PWM_BITS-1:0] c_pwm_last  = PWM_BITS'(MAX_BRIGHTNESS - 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE  = 2'd0,
    MODE_WRAP_UP = 2'd1,
    MODE_WRAP_DN = 2'd2,
    MODE_FREEZE  = 2'd3
  } mode_t;

  mode_t w_mode;
  assign w_mode = mode_t'(mode);

  logic [c_tw-1:0]     tick_cnt_q, tick_cnt_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [c_pw-1:0]     pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_CNT-1:0]  led_q, led_d;
  logic [LED_CNT-1:0][PWM_BITS-1:0] level_q, level_d;

  logic        w_tick;
  logic        w_step_due;
  logic [15:0] w_step_lim;

  always_comb begin
    w_tick     = enable && (tick_cnt_q == c_tick_last);
    tick_cnt_d = tick_cnt_q;
    if (enable) begin
      tick_cnt_d = w_tick ? '0 : tick_cnt_q + c_tw'(1);
    end

    // A step_ticks of zero behaves like one; >= lets a lowered value act at once.
    w_step_lim = (step_ticks == 16'd0) ? 16'd0 : step_ticks - 16'd1;
    step_cnt_d = step_cnt_q;
    w_step_due = 1'b0;
    if (w_tick) begin
      if (step_cnt_q >= w_step_lim) begin
        step_cnt_d = '0;
        w_step_due = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
    end

    step_d = w_step_due && (w_mode != MODE_FREEZE);
    pos_d  = pos_q;
    dir_d  = dir_q;
    if (step_d) begin
      case (w_mode)
        MODE_BOUNCE: begin
          if (dir_q && (pos_q == c_pos_last)) begin
            dir_d = 1'b0;
            pos_d = c_pos_last - c_pw'(1);
          end else if (!dir_q && (pos_q == '0)) begin
            dir_d = 1'b1;
            pos_d = c_pw'(1);
          end else begin
            pos_d = dir_q ? pos_q + c_pw'(1) : pos_q - c_pw'(1);
          end
        end
        MODE_WRAP_UP: begin
          dir_d = 1'b1;
          pos_d = (pos_q == c_pos_last) ? '0 : pos_q + c_pw'(1);
        end
        MODE_WRAP_DN: begin
          dir_d = 1'b0;
          pos_d = (pos_q == '0) ? c_pos_last : pos_q - c_pw'(1);
        end
        default: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end

    pwm_cnt_d = (pwm_cnt_q == c_pwm_last) ? '0 : pwm_cnt_q + PWM_BITS'(1);

    for (int i = 0; i < LED_CNT; i++) begin
      // The load of the newly lit channel takes priority over its fade.
      level_d[i] = level_q[i];
      if (step_d && (pos_d == c_pw'(i))) begin
        level_d[i] = c_full;
      end else if (w_tick) begin
        level_d[i] = (level_q[i] > fade_rate) ? level_q[i] - fade_rate : '0;
      end
      led_d[i] = (level_q[i] > pwm_cnt_q) && !mask[i];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      level_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      level_q    <= level_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule
`default_nettype wire
